// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-memory bus interface between the MEM-stage access unit
//               (master) and the external data memory (slave). Single
//               outstanding req/ack transaction; ack sampled at rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data-memory access unit. Posted FIFO store buffer,
//               byte/half/word lane steering, sign/zero-extended loads over a
//               registered req/ack bus, and a pipeline stall output.
//               Optional macro MISALIGN_TRAP_EN: flag misaligned half/word
//               accesses instead of truncating the address.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4,
    parameter int CNT_W    = $clog2(SB_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              m_load,
    input  logic              m_store,
    input  logic [1:0]        m_type,
    input  logic              m_sign,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    output logic              m_stall,
    output logic [31:0]       m_rdata,
    output logic              m_misalign,
    output logic [CNT_W-1:0]  sb_count,
    mem_access_unit_if.master bus
);

    localparam int         PTR_W     = $clog2(SB_DEPTH);
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SDRAIN = 2'd1,
        LREQ   = 2'd2,
        LDONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_req, w_req_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [3:0]          r_be, w_be_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt;

    logic [31:0]         r_ld_word;
    logic                r_discard;

    logic [ADDR_W-1:0]   r_sb_addr  [SB_DEPTH];
    logic [3:0]          r_sb_be    [SB_DEPTH];
    logic [31:0]         r_sb_wdata [SB_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_misalign;
    logic                w_store_req;
    logic                w_load_req;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_ld_ok;
    logic [ADDR_W-1:0]   w_aligned_addr;
    logic [3:0]          w_lane_be;
    logic [31:0]         w_lane_wdata;
    logic [15:0]         w_ld_half;
    logic [7:0]          w_ld_byte;
    logic [31:0]         w_ld_ext;

`ifdef MISALIGN_TRAP_EN
    // Flag half accesses off a halfword boundary and word accesses off a word boundary
    always_comb begin
        w_misalign = 1'b0;
        if (m_valid && (m_load || m_store)) begin
            if (m_type == TYPE_HALF) begin
                w_misalign = m_addr[0];
            end else if (m_type != TYPE_BYTE) begin
                w_misalign = |m_addr[1:0];
            end
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    // A trapped access neither stores, loads nor stalls; store wins over load
    assign w_store_req    = m_valid && m_store && !w_misalign;
    assign w_load_req     = m_valid && m_load && !m_store && !w_misalign;
    assign w_full         = (r_count == CNT_W'(SB_DEPTH));
    assign w_push         = w_store_req && !w_full;
    assign w_ld_ok        = (r_state == LDONE) && !r_discard;
    assign w_aligned_addr = {m_addr[ADDR_W-1:2], 2'b00};

    // Byte-enable and replicated write-data generation; low address bits
    // below the natural alignment are ignored
    always_comb begin
        w_lane_be    = 4'b1111;
        w_lane_wdata = m_wdata;
        case (m_type)
            TYPE_HALF: begin
                w_lane_be    = m_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{m_wdata[15:0]}};
            end
            TYPE_BYTE: begin
                w_lane_be    = 4'b0001 << m_addr[1:0];
                w_lane_wdata = {4{m_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Select the addressed lane of the captured read word and extend it
    always_comb begin
        w_ld_half = m_addr[1] ? r_ld_word[31:16] : r_ld_word[15:0];
        case (m_addr[1:0])
            2'd1:    w_ld_byte = r_ld_word[15:8];
            2'd2:    w_ld_byte = r_ld_word[23:16];
            2'd3:    w_ld_byte = r_ld_word[31:24];
            default: w_ld_byte = r_ld_word[7:0];
        endcase
        w_ld_ext = r_ld_word;
        case (m_type)
            TYPE_HALF: w_ld_ext = {{16{m_sign & w_ld_half[15]}}, w_ld_half};
            TYPE_BYTE: w_ld_ext = {{24{m_sign & w_ld_byte[7]}}, w_ld_byte};
            default:   ;
        endcase
    end

    // Store-buffer pointers and occupancy; full is judged on the registered count
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Store-buffer payload storage, written at the tail on push
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_sb_addr[r_wr_ptr]  <= w_aligned_addr;
            r_sb_be[r_wr_ptr]    <= w_lane_be;
            r_sb_wdata[r_wr_ptr] <= w_lane_wdata;
        end
    end

    // Next-state and next bus-register values; bus fields hold while a request is open
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_be_nxt    = r_be;
        w_wdata_nxt = r_wdata;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load_req && (r_count == '0)) begin
                    w_state_nxt = LREQ;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_addr_nxt  = w_aligned_addr;
                    w_be_nxt    = w_lane_be;
                    w_wdata_nxt = '0;
                end else if (r_count != '0) begin
                    w_state_nxt = SDRAIN;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_sb_addr[r_rd_ptr];
                    w_be_nxt    = r_sb_be[r_rd_ptr];
                    w_wdata_nxt = r_sb_wdata[r_rd_ptr];
                end
            end
            SDRAIN: begin
                if (bus.bus_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_addr_nxt  = '0;
                    w_be_nxt    = '0;
                    w_wdata_nxt = '0;
                end
            end
            LREQ: begin
                if (bus.bus_ack) begin
                    w_state_nxt = LDONE;
                    w_req_nxt   = 1'b0;
                    w_addr_nxt  = '0;
                    w_be_nxt    = '0;
                end
            end
            LDONE: begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, bus registers, read capture and the abandoned-load marker
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_ld_word <= '0;
            r_discard <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_be    <= w_be_nxt;
            r_wdata <= w_wdata_nxt;
            if ((r_state == LREQ) && bus.bus_ack) begin
                r_ld_word <= bus.bus_rdata;
            end
            // A load that went away mid-request must not hand its data to a later one
            if (r_state == IDLE) begin
                r_discard <= 1'b0;
            end else if ((r_state == LREQ) && !w_load_req) begin
                r_discard <= 1'b1;
            end
        end
    end

    assign bus.bus_req   = r_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;

    assign m_stall    = (w_store_req && w_full) || (w_load_req && !w_ld_ok);
    assign m_rdata    = (w_load_req && w_ld_ok) ? w_ld_ext : 32'd0;
    assign m_misalign = w_misalign;
    assign sb_count   = r_count;

endmodule
`default_nettype wire
